// File: rtl/scroll_executor.sv
// scroll_executor: moves rows of a text-buffer region up/down by N lines cell by cell
// through a single RAM port, blanking the vacated rows; one pending request slot.
module scroll_executor #(
  parameter int LINES = 50,
  parameter int COLUMNS = 80,
  parameter int CELL_W = 24,
  parameter logic [CELL_W-1:0] BLANK_CELL = 24'h000020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scroll_req,
  input  logic              scroll_dir,
  input  logic [7:0]        scroll_step,
  input  logic [7:0]        scroll_top,
  input  logic [7:0]        scroll_bottom,
  input  logic              scroll_reset,
  output logic [7:0]        ram_row,
  output logic [7:0]        ram_col,
  output logic              ram_rd_en,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [CELL_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              dropped
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_RD = 3'd2, S_WR = 3'd3,
                         S_BLANK = 3'd4, S_DONE = 3'd5;
  localparam logic [8:0] LINES9 = 9'(LINES);
  localparam logic [7:0] LAST_COL = 8'(COLUMNS - 1);

  logic [2:0] r_state;
  logic       r_dir, r_pv, r_pdir, r_dropped;
  logic [7:0] r_step, r_top, r_bot, r_row, r_col, r_pstep, r_ptop, r_pbot;

  function automatic logic row_copies(input logic dir, input logic [7:0] row, top, bot,
                                      input logic [8:0] n);
    return dir ? ({1'b0, row} >= {1'b0, top} + n) : ({1'b0, row} + n <= {1'b0, bot});
  endfunction

  logic [8:0] w_h, w_n;
  logic [7:0] w_next_row, w_src, w_lstep, w_ltop, w_lbot;
  logic [2:0] w_cell_next;
  logic       w_noop, w_last_col, w_last_row, w_copy, w_next_copy, w_take, w_direct;
  logic       w_ldir, w_rd, w_we;

  assign w_h = {1'b0, r_bot} - {1'b0, r_top} + 9'd1;
  assign w_n = ({1'b0, r_step} < w_h) ? {1'b0, r_step} : w_h;
  assign w_noop = (r_step == 8'd0) || (r_top > r_bot) || ({1'b0, r_bot} >= LINES9);
  assign w_last_col = r_col == LAST_COL;
  assign w_last_row = r_dir ? (r_row == r_top) : (r_row == r_bot);
  assign w_next_row = r_dir ? r_row - 8'd1 : r_row + 8'd1;
  assign w_src = r_dir ? r_row - w_n[7:0] : r_row + w_n[7:0];
  assign w_copy = row_copies(r_dir, r_row, r_top, r_bot, w_n);
  assign w_next_copy = row_copies(r_dir, w_next_row, r_top, r_bot, w_n);
  assign w_cell_next = !w_last_col ? (w_copy ? S_RD : S_BLANK) :
                       w_last_row ? S_DONE : (w_next_copy ? S_RD : S_BLANK);
  // A pending request takes precedence over a fresh strobe; the strobe then refills the slot.
  assign w_take = (r_state == S_IDLE) && (r_pv || scroll_req);
  assign w_direct = (r_state == S_IDLE) && !r_pv;
  assign w_ldir = r_pv ? r_pdir : scroll_dir;
  assign w_lstep = r_pv ? r_pstep : scroll_step;
  assign w_ltop = r_pv ? r_ptop : scroll_top;
  assign w_lbot = r_pv ? r_pbot : scroll_bottom;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_dir <= 1'b0;
      r_step <= '0;
      r_top <= '0;
      r_bot <= '0;
      r_row <= '0;
      r_col <= '0;
      r_pv <= 1'b0;
      r_pdir <= 1'b0;
      r_pstep <= '0;
      r_ptop <= '0;
      r_pbot <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (scroll_reset) r_state <= S_IDLE;
      else case (r_state)
        S_IDLE: if (w_take) begin
          r_dir <= w_ldir;
          r_step <= w_lstep;
          r_top <= w_ltop;
          r_bot <= w_lbot;
          r_row <= w_ldir ? w_lbot : w_ltop;
          r_col <= '0;
          r_state <= S_SETUP;
        end
        S_SETUP: r_state <= w_noop ? S_DONE : (w_copy ? S_RD : S_BLANK);
        S_RD: r_state <= S_WR;
        S_WR, S_BLANK: begin
          r_state <= w_cell_next;
          r_col <= w_last_col ? 8'd0 : r_col + 8'd1;
          if (w_last_col && !w_last_row) r_row <= w_next_row;
        end
        default: r_state <= S_IDLE;
      endcase
      if (scroll_reset) r_pv <= 1'b0;
      else if (scroll_req && !w_direct) begin
        r_pv <= 1'b1;
        r_pdir <= scroll_dir;
        r_pstep <= scroll_step;
        r_ptop <= scroll_top;
        r_pbot <= scroll_bottom;
        if (r_pv && r_state != S_IDLE) r_dropped <= 1'b1;
      end else if (w_take) r_pv <= 1'b0;
    end
  end

  assign w_rd = r_state == S_RD;
  assign w_we = (r_state == S_WR) || (r_state == S_BLANK);
  assign ram_rd_en = w_rd;
  assign ram_we = w_we;
  assign ram_row = w_rd ? w_src : (w_we ? r_row : 8'd0);
  assign ram_col = (w_rd || w_we) ? r_col : 8'd0;
  assign ram_wdata = (r_state == S_WR) ? ram_rdata : ((r_state == S_BLANK) ? BLANK_CELL : '0);
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = r_state == S_DONE;
  assign dropped = r_dropped;
endmodule

// File: tb/tb_scroll_executor.sv
// tb_scroll_executor: random and directed scroll ops against a screen-image model
// plus a behavioural RAM; checks image, latency, strobe counts, pending/abort/reset.
module tb_scroll_executor;
  localparam int LINES = 8, COLUMNS = 4, CELL_W = 24;
  localparam logic [CELL_W-1:0] BLANK = 24'h000020;

  logic clk = 1'b0, rst = 1'b0;
  logic scroll_req = 1'b0, scroll_dir = 1'b0, scroll_reset = 1'b0;
  logic [7:0] scroll_step = '0, scroll_top = '0, scroll_bottom = '0;
  logic [7:0] ram_row, ram_col;
  logic ram_rd_en, ram_we, busy, done, dropped;
  logic [CELL_W-1:0] ram_rdata, ram_wdata;

  logic [CELL_W-1:0] mem [LINES][COLUMNS];
  logic [CELL_W-1:0] model_img [LINES][COLUMNS];
  int n_chk = 0, n_bad = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, n_both = 0, n_oob = 0;

  always #5 clk = ~clk;

  scroll_executor #(.LINES(LINES), .COLUMNS(COLUMNS), .CELL_W(CELL_W), .BLANK_CELL(BLANK)) dut (
    .clk(clk), .rst(rst), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
    .scroll_step(scroll_step), .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
    .scroll_reset(scroll_reset), .ram_row(ram_row), .ram_col(ram_col), .ram_rd_en(ram_rd_en),
    .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_wdata(ram_wdata), .busy(busy), .done(done),
    .dropped(dropped)
  );

  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < LINES; r++)
        for (int c = 0; c < COLUMNS; c++) mem[r][c] <= CELL_W'($urandom);
    end else if (ram_row < LINES && ram_col < COLUMNS) begin
      if (ram_we) mem[ram_row][ram_col] <= ram_wdata;
      if (ram_rd_en) ram_rdata <= mem[ram_row][ram_col];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n_rd += int'(ram_rd_en);
      n_wr += int'(ram_we);
      n_done += int'(done);
      n_both += int'(ram_rd_en && ram_we);
      n_oob += int'((ram_rd_en || ram_we) && (ram_row >= LINES || ram_col >= COLUMNS));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic sync_model();
    for (int r = 0; r < LINES; r++)
      for (int c = 0; c < COLUMNS; c++) model_img[r][c] = mem[r][c];
  endtask

  function automatic int img_errs();
    int e = 0;
    for (int r = 0; r < LINES; r++)
      for (int c = 0; c < COLUMNS; c++) e += int'(mem[r][c] !== model_img[r][c]);
    return e;
  endfunction

  // Whole-image view of a scroll: each region row takes the row n away or becomes blank.
  task automatic apply_model(input logic d, input int s, input int t, input int b,
                             output int lat, output int cp, output int bl);
    logic [CELL_W-1:0] old [LINES][COLUMNS];
    int h, n, src;
    cp = 0;
    bl = 0;
    lat = 2;
    if (s == 0 || t > b || b >= LINES) return;
    for (int r = 0; r < LINES; r++)
      for (int c = 0; c < COLUMNS; c++) old[r][c] = model_img[r][c];
    h = b - t + 1;
    n = (s < h) ? s : h;
    for (int r = t; r <= b; r++) begin
      src = d ? r - n : r + n;
      if (src >= t && src <= b) begin
        cp++;
        for (int c = 0; c < COLUMNS; c++) model_img[r][c] = old[src][c];
      end else begin
        bl++;
        for (int c = 0; c < COLUMNS; c++) model_img[r][c] = BLANK;
      end
    end
    lat = 2 + (2 * cp + bl) * COLUMNS;
  endtask

  task automatic send(input logic d, input logic [7:0] s, t, b);
    scroll_req = 1'b1;
    scroll_dir = d;
    scroll_step = s;
    scroll_top = t;
    scroll_bottom = b;
    @(negedge clk);
    scroll_req = 1'b0;
  endtask

  task automatic run_op(input logic d, input logic [7:0] s, t, b);
    int lat, cp, bl, k, rd0, wr0;
    apply_model(d, int'(s), int'(t), int'(b), lat, cp, bl);
    rd0 = n_rd;
    wr0 = n_wr;
    send(d, s, t, b);
    k = 1;
    check("busy_setup", busy, 1);
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, lat);
    check("busy_done", busy, 0);
    check("reads", n_rd - rd0, cp * COLUMNS);
    check("writes", n_wr - wr0, (cp + bl) * COLUMNS);
    @(negedge clk);
    check("image", img_errs(), 0);
  endtask

  initial begin
    int lat, cp, bl, dn0, k;
    logic d;
    logic [7:0] s, t, b;
    repeat (3) @(negedge clk);
    check("rst_outs", {busy, done, dropped, ram_rd_en, ram_we, ram_row, ram_col}, 0);
    check("rst_wdata", ram_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    sync_model();
    run_op(1'b0, 8'd1, 8'd0, 8'd2);
    run_op(1'b1, 8'd2, 8'd1, 8'd3);
    run_op(1'b0, 8'd200, 8'd2, 8'd5);
    run_op(1'b1, 8'd0, 8'd0, 8'd7);
    run_op(1'b0, 8'd1, 8'd4, 8'd3);
    run_op(1'b1, 8'd3, 8'd0, 8'd7);
    for (int i = 0; i < 25; i++) begin
      d = 1'($urandom);
      t = 8'($urandom_range(0, LINES - 1));
      b = 8'($urandom_range(0, LINES));
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, LINES));
      run_op(d, s, t, b);
    end
    // three requests during one op: second is overwritten by the third
    check("drop0", dropped, 0);
    dn0 = n_done;
    apply_model(1'b0, 1, 0, 7, lat, cp, bl);
    apply_model(1'b1, 2, 2, 6, lat, cp, bl);
    send(1'b0, 8'd1, 8'd0, 8'd7);
    repeat (2) @(negedge clk);
    send(1'b1, 8'd3, 8'd0, 8'd7);
    check("drop_one", dropped, 0);
    repeat (2) @(negedge clk);
    send(1'b1, 8'd2, 8'd2, 8'd6);
    check("drop_set", dropped, 1);
    k = 0;
    while (n_done - dn0 < 2 && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    check("pend_dones", n_done - dn0, 2);
    check("pend_image", img_errs(), 0);
    // abort mid-copy with a pending request queued
    dn0 = n_done;
    send(1'b0, 8'd1, 8'd0, 8'd7);
    send(1'b1, 8'd1, 8'd0, 8'd7);
    repeat (4) @(negedge clk);
    scroll_reset = 1'b1;
    @(negedge clk);
    scroll_reset = 1'b0;
    check("abort_strobes", {ram_rd_en, ram_we, busy}, 0);
    repeat (80) @(negedge clk);
    check("abort_nodone", n_done - dn0, 0);
    check("abort_idle", busy, 0);
    sync_model();
    run_op(1'b1, 8'd1, 8'd1, 8'd6);
    // asynchronous reset mid-operation
    send(1'b0, 8'd2, 8'd0, 8'd7);
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("arst_outs", {busy, done, dropped, ram_rd_en, ram_we, ram_row, ram_col}, 0);
    check("arst_wdata", ram_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sync_model();
    run_op(1'b0, 8'd3, 8'd2, 8'd8);
    run_op(1'b0, 8'd2, 8'd1, 8'd6);
    check("no_overlap", n_both, 0);
    check("addr_range", n_oob, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
